dac_arbiter: RTL and testbench



---
 rtl/dac_arbiter.sv | 149 ++++++++++++++
 tb/tb_dac_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_arbiter.sv
// Two-source arbiter in front of the DAC121S101 SPI frame engine: one-deep
// pending slot per requester, round-robin service, CS-high gap and done watchdog.
module dac_arb_slot (
  input  logic        i_Clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] data,
  input  logic        grant,
  output logic        pend,
  output logic [11:0] slot_data
);
  // A start in the grant cycle wins: the grant already took the old code.
  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      slot_data <= '0;
    end else if (start) begin
      pend      <= 1'b1;
      slot_data <= data;
    end else if (grant) begin
      pend      <= 1'b0;
    end
  end
endmodule

module dac_arbiter #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_Clk,
  input  logic        rst_n,
  input  logic        req0_start,
  input  logic [11:0] req0_data,
  output logic        req0_busy,
  output logic        req0_done,
  input  logic        req1_start,
  input  logic [11:0] req1_data,
  output logic        req1_busy,
  output logic        req1_done,
  output logic        dac_start,
  output logic [11:0] dac_data,
  input  logic        dac_done,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);
  localparam int NUM_REQ = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [1:0]  S_AFTER   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  logic [1:0]                    state;
  logic                          last_grant;
  logic                          sel;
  logic [15:0]                   timer;
  logic [15:0]                   gap_cnt;
  logic [NUM_REQ-1:0]            req_start;
  logic [NUM_REQ-1:0]            pend;
  logic [NUM_REQ-1:0]            grant_vec;
  logic [NUM_REQ-1:0]            req_done;
  logic [NUM_REQ-1:0][11:0]      req_data;
  logic [NUM_REQ-1:0][11:0]      slot_data;

  assign req_start = {req1_start, req0_start};
  assign req_data  = {req1_data, req0_data};

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    dac_arb_slot u_slot (
      .i_Clk     (i_Clk),
      .rst_n     (rst_n),
      .start     (req_start[gi]),
      .data      (req_data[gi]),
      .grant     (grant_vec[gi]),
      .pend      (pend[gi]),
      .slot_data (slot_data[gi])
    );
  end

  // On a tie the requester that did not own the previous frame goes next.
  always_comb begin
    sel       = (&pend) ? ~last_grant : pend[1];
    grant_vec = '0;
    if (state == S_IDLE && |pend) grant_vec[sel] = 1'b1;
  end

  assign req0_busy = pend[0] | (o_grant[0] & (state == S_ISSUE || state == S_WAIT));
  assign req1_busy = pend[1] | (o_grant[1] & (state == S_ISSUE || state == S_WAIT));
  assign req0_done = req_done[0];
  assign req1_done = req_done[1];

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      o_grant    <= '0;
      dac_start  <= 1'b0;
      dac_data   <= '0;
      req_done   <= '0;
      o_timeout  <= 1'b0;
      timer      <= '0;
      gap_cnt    <= '0;
    end else begin
      dac_start <= 1'b0;
      req_done  <= '0;
      o_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|pend) begin
            dac_data   <= slot_data[sel];
            o_grant    <= grant_vec;
            last_grant <= sel;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          dac_start <= 1'b1;
          timer     <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (dac_done) begin
            req_done <= o_grant;
            o_grant  <= '0;
            gap_cnt  <= '0;
            state    <= S_AFTER;
          end else if (timer == TMO_LAST) begin
            o_timeout <= 1'b1;
            req_done  <= o_grant;
            o_grant   <= '0;
            gap_cnt   <= '0;
            state     <= S_AFTER;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_arbiter.sv
// Directed bench for dac_arbiter: single-frame vector table plus hand-written
// tie, fairness, overwrite, timeout and mid-frame reset sequences.
module tb_dac_arbiter;
  logic        i_Clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_start = 1'b0, req1_start = 1'b0;
  logic [11:0] req0_data = '0, req1_data = '0;
  logic        req0_busy, req0_done, req1_busy, req1_done;
  logic        dac_start, dac_done = 1'b0, o_timeout;
  logic [11:0] dac_data;
  logic [1:0]  o_grant;

  int n_pass = 0, n_total = 0;
  int n_start = 0, n_done0 = 0, n_done1 = 0;

  dac_arbiter #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(1024)) dut (
    .i_Clk(i_Clk), .rst_n(rst_n),
    .req0_start(req0_start), .req0_data(req0_data), .req0_busy(req0_busy), .req0_done(req0_done),
    .req1_start(req1_start), .req1_data(req1_data), .req1_busy(req1_busy), .req1_done(req1_done),
    .dac_start(dac_start), .dac_data(dac_data), .dac_done(dac_done),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #20 i_Clk = ~i_Clk;

  always @(negedge i_Clk) begin
    if (rst_n) begin
      n_start = n_start + int'(dac_start);
      n_done0 = n_done0 + int'(req0_done);
      n_done1 = n_done1 + int'(req1_done);
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          req;
    logic [11:0] data;
    int          dly;
    logic [1:0]  exp_g;
  } vec_t;
  vec_t tbl[4];

  task automatic tick();
    @(posedge i_Clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pulse(input bit r, input logic [11:0] d);
    if (r) begin req1_start = 1'b1; req1_data = d; end
    else   begin req0_start = 1'b1; req0_data = d; end
    tick();
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (!dac_start && lat < 200) begin tick(); lat++; end
    if (!dac_start) check("dac_start_seen", 0, 1);
  endtask

  task automatic give_done(input int dly);
    repeat (dly - 1) tick();
    dac_done = 1'b1;
    tick();
    dac_done = 1'b0;
  endtask

  initial begin
    int lat, d0, d1, s0;
    tbl[0] = '{1'b0, 12'h7FF, 10, 2'b01};
    tbl[1] = '{1'b1, 12'hABC, 3,  2'b10};
    tbl[2] = '{1'b0, 12'h000, 1,  2'b01};
    tbl[3] = '{1'b1, 12'hFFF, 1,  2'b10};

    #5;
    check("reset_outputs", {dac_start, dac_data, o_grant, o_timeout,
                            req0_busy, req0_done, req1_busy, req1_done}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single-frame vectors
    foreach (tbl[i]) begin
      pulse(tbl[i].req, tbl[i].data);
      wait_start(lat);
      check("vec_latency", lat, 2);
      check("vec_data", dac_data, tbl[i].data);
      check("vec_grant", o_grant, tbl[i].exp_g);
      check("vec_busy", {req1_busy, req0_busy}, tbl[i].exp_g);
      give_done(tbl[i].dly);
      check("vec_done", {req1_done, req0_done}, tbl[i].exp_g);
      check("vec_busy_fall", {req1_busy, req0_busy}, 0);
      check("vec_grant_clr", o_grant, 0);
      check("vec_data_hold", dac_data, tbl[i].data);
      tick();
      check("vec_done_1cyc", {req1_done, req0_done}, 0);
      repeat (3) tick();
    end

    // tie: requester 0 first, then requester 1 after the gap
    d0 = n_done0; d1 = n_done1;
    req1_start = 1'b1; req1_data = 12'h200;
    pulse(1'b0, 12'h100);
    wait_start(lat);
    check("tie_first_data", dac_data, 12'h100);
    check("tie_first_grant", o_grant, 2'b01);
    give_done(4);
    wait_start(lat);
    check("tie_gap_latency", lat, 4);
    check("tie_second_data", dac_data, 12'h200);
    check("tie_second_grant", o_grant, 2'b10);
    give_done(2);
    tick();
    check("tie_done0_count", n_done0 - d0, 1);
    check("tie_done1_count", n_done1 - d1, 1);
    repeat (3) tick();

    // fairness: requester 0 holds start high, requester 1 re-requests after its done
    req0_start = 1'b1; req0_data = 12'h0A0;
    req1_start = 1'b1; req1_data = 12'h0B0;
    tick();
    req1_start = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_start(lat);
      check("fair_grant", o_grant, (f % 2 == 0) ? 2'b01 : 2'b10);
      check("fair_data", dac_data, (f % 2 == 0) ? 12'h0A0 : 12'h0B0);
      give_done(2);
      if (f == 1) begin req1_start = 1'b1; tick(); req1_start = 1'b0; end
    end
    req0_start = 1'b0;
    wait_start(lat);
    check("fair_drain_grant", o_grant, 2'b01);
    give_done(1);
    repeat (5) tick();
    check("fair_idle_busy", {req1_busy, req0_busy}, 0);

    // overwrite: three requester-1 starts during a requester-0 frame
    d1 = n_done1;
    pulse(1'b0, 12'h555);
    wait_start(lat);
    pulse(1'b1, 12'h010);
    pulse(1'b1, 12'h020);
    pulse(1'b1, 12'h030);
    give_done(5);
    check("ovw_done0", {req1_done, req0_done}, 2'b01);
    s0 = n_start;
    wait_start(lat);
    check("ovw_data", dac_data, 12'h030);
    check("ovw_grant", o_grant, 2'b10);
    give_done(3);
    repeat (10) tick();
    check("ovw_one_frame", n_start - s0, 1);
    check("ovw_one_done", n_done1 - d1, 1);

    // timeout: no dac_done; requester 1 pending behind it
    pulse(1'b0, 12'h321);
    wait_start(lat);
    pulse(1'b1, 12'h654);
    repeat (1022) tick();
    check("tmo_early", o_timeout, 0);
    tick();
    check("tmo_pulse", o_timeout, 1);
    check("tmo_done0", {req1_done, req0_done}, 2'b01);
    check("tmo_grant_clr", o_grant, 0);
    dac_done = 1'b1;
    tick();
    dac_done = 1'b0;
    check("tmo_stray_done", {o_timeout, req1_done, req0_done}, 0);
    wait_start(lat);
    check("tmo_next_data", dac_data, 12'h654);
    check("tmo_next_grant", o_grant, 2'b10);
    give_done(1);
    check("tmo_next_done", {req1_done, req0_done}, 2'b10);
    repeat (4) tick();

    // reset mid-frame with requester 1 pending
    pulse(1'b0, 12'h111);
    wait_start(lat);
    pulse(1'b1, 12'h222);
    repeat (2) tick();
    check("rst_pre_busy", {req1_busy, req0_busy}, 2'b11);
    #5 rst_n = 1'b0;
    #1;
    check("rst_outputs", {dac_start, dac_data, o_grant, o_timeout,
                          req0_busy, req0_done, req1_busy, req1_done}, 0);
    s0 = n_start;
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("rst_no_start", n_start - s0, 0);
    pulse(1'b1, 12'h0F0);
    wait_start(lat);
    check("rst_new_latency", lat, 2);
    check("rst_new_data", dac_data, 12'h0F0);
    give_done(1);
    check("rst_new_done", {req1_done, req0_done}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
